// File: rtl/riscv_np_pkg.sv
// Shared types and constants for the RV32I pipeline ID/EX stage.
package riscv_np_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

   // Contents of the ID/EX pipeline register.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [XLEN-1:0]   rs1_val;
      logic [XLEN-1:0]   rs2_val;
      logic [XLEN-1:0]   imm;
      logic              use_imm;
      alu_op_e           alu_op;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
   } ex_regs_t;

   // The register file has no write-through, so a value being written back
   // this cycle is picked up here as the operand is captured. x0 is never bypassed.
   function automatic logic [XLEN-1:0] wb_bypass(input logic [REG_AW-1:0] rs,
                                                 input logic [XLEN-1:0]   rf_data,
                                                 input logic [REG_AW-1:0] wb_rd,
                                                 input logic              wb_we,
                                                 input logic [XLEN-1:0]   wb_result);
      return (wb_we && (wb_rd != '0) && (wb_rd == rs)) ? wb_result : rf_data;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the pipeline and the ID/EX stage.
// master = surrounding pipeline, slave = the stage itself.
interface id_ex_stage_if;
   import riscv_np_pkg::*;

   // ID side
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic [REG_AW-1:0] id_rd;
   logic [XLEN-1:0]   id_rs1_data;
   logic [XLEN-1:0]   id_rs2_data;
   logic [XLEN-1:0]   id_imm;
   logic              id_use_imm;
   alu_op_e           id_alu_op;
   logic              id_reg_write;
   logic              id_mem_read;
   // control from EX / MEM
   logic              flush;
   logic              hold;
   // forwarding sources
   logic [REG_AW-1:0] exm_rd;
   logic              exm_reg_write;
   logic [XLEN-1:0]   exm_result;
   logic [REG_AW-1:0] mwb_rd;
   logic              mwb_reg_write;
   logic [XLEN-1:0]   mwb_result;
   // EX side
   logic              ex_valid;
   logic [XLEN-1:0]   A;
   logic [XLEN-1:0]   B;
   alu_op_e           ALUOp;
   logic [XLEN-1:0]   ex_store_data;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              id_stall;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
             id_use_imm, id_alu_op, id_reg_write, id_mem_read, flush, hold,
             exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write, mwb_result,
      input  ex_valid, A, B, ALUOp, ex_store_data, ex_rd, ex_reg_write,
             ex_mem_read, id_stall
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
             id_use_imm, id_alu_op, id_reg_write, id_mem_read, flush, hold,
             exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write, mwb_result,
      output ex_valid, A, B, ALUOp, ex_store_data, ex_rd, ex_reg_write,
             ex_mem_read, id_stall
   );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// EX operand forwarding mux: EX/MEM beats MEM/WB beats the captured value.
module fwd_mux
   import riscv_np_pkg::*;
(
   input  logic [REG_AW-1:0] rs,
   input  logic [XLEN-1:0]   cap_val,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic              exm_reg_write,
   input  logic [XLEN-1:0]   exm_result,
   input  logic [REG_AW-1:0] mwb_rd,
   input  logic              mwb_reg_write,
   input  logic [XLEN-1:0]   mwb_result,
   output logic [XLEN-1:0]   fwd_val
);

   // Pick the youngest producer of rs; x0 always reads the captured value.
   always_comb begin
      // NOTE: fwd_val gets a default before any branch so no path leaves it
      // unassigned, which would otherwise infer a latch.
      fwd_val = cap_val;
      if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs))
         fwd_val = exm_result;
      else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs))
         fwd_val = mwb_result;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush/hold control and
// EX-side operand forwarding for the RV32I pipeline.
module id_ex_stage
   import riscv_np_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   id_ex_stage_if.slave bus
);

   ex_regs_t        ex_q;
   ex_regs_t        id_d;
   logic            lu;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

   // A load in EX whose rd is read by the instruction in ID cannot be
   // forwarded in time; the consumer waits one cycle behind a bubble.
   assign lu = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && bus.id_valid &&
               ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));

   // A flush discards whatever ID holds, so there is nothing to stall for.
   assign bus.id_stall = (lu || bus.hold) && !bus.flush;

   // Assemble the next stage contents from ID, with writeback bypass on capture.
   always_comb begin
      id_d           = '0;
      id_d.valid     = bus.id_valid;
      id_d.rs1       = bus.id_rs1;
      id_d.rs2       = bus.id_rs2;
      id_d.rs1_val   = wb_bypass(bus.id_rs1, bus.id_rs1_data, bus.mwb_rd,
                                 bus.mwb_reg_write, bus.mwb_result);
      id_d.rs2_val   = wb_bypass(bus.id_rs2, bus.id_rs2_data, bus.mwb_rd,
                                 bus.mwb_reg_write, bus.mwb_result);
      id_d.imm       = bus.id_imm;
      id_d.use_imm   = bus.id_use_imm;
      id_d.alu_op    = bus.id_alu_op;
      id_d.rd        = bus.id_rd;
      id_d.reg_write = bus.id_reg_write;
      id_d.mem_read  = bus.id_mem_read;
   end

   // Stage register update: flush > hold > load-use bubble > capture.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every field is cleared by reset, not only valid, so an in-flight
      // instruction leaves no stale rd/op visible on the outputs.
      if (!rst_n)
         ex_q <= '0;
      else if (bus.flush)
         // NOTE: sequential state uses non-blocking assignment so every
         // register samples pre-edge values regardless of statement order.
         ex_q.valid <= 1'b0;
      else if (bus.hold)
         ex_q <= ex_q;
      else if (lu)
         ex_q.valid <= 1'b0;
      else
         ex_q <= id_d;
   end

   fwd_mux u_fwd_rs1 (
      .rs            (ex_q.rs1),
      .cap_val       (ex_q.rs1_val),
      .exm_rd        (bus.exm_rd),
      .exm_reg_write (bus.exm_reg_write),
      .exm_result    (bus.exm_result),
      .mwb_rd        (bus.mwb_rd),
      .mwb_reg_write (bus.mwb_reg_write),
      .mwb_result    (bus.mwb_result),
      .fwd_val       (fwd_rs1)
   );

   fwd_mux u_fwd_rs2 (
      .rs            (ex_q.rs2),
      .cap_val       (ex_q.rs2_val),
      .exm_rd        (bus.exm_rd),
      .exm_reg_write (bus.exm_reg_write),
      .exm_result    (bus.exm_result),
      .mwb_rd        (bus.mwb_rd),
      .mwb_reg_write (bus.mwb_reg_write),
      .mwb_result    (bus.mwb_result),
      .fwd_val       (fwd_rs2)
   );

   assign bus.ex_valid      = ex_q.valid;
   assign bus.A             = fwd_rs1;
   assign bus.B             = ex_q.use_imm ? ex_q.imm : fwd_rs2;
   assign bus.ex_store_data = fwd_rs2;
   assign bus.ALUOp         = ex_q.alu_op;
   assign bus.ex_rd         = ex_q.rd;
   assign bus.ex_reg_write  = ex_q.reg_write && ex_q.valid;
   assign bus.ex_mem_read   = ex_q.mem_read && ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios, then randomized
// traffic against a transaction-level reference model.
module tb_id_ex_stage;
   import riscv_np_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // What the model believes is sitting in EX.
   typedef struct {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] v1, v2, imm;
      logic        use_imm, rw, mr;
      logic [1:0]  op;
   } ex_ref_t;

   ex_ref_t m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
      bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_use_imm = 0;
      bus.id_alu_op = ALU_ADD; bus.id_reg_write = 0; bus.id_mem_read = 0;
      bus.flush = 0; bus.hold = 0;
      bus.exm_rd = 0; bus.exm_reg_write = 0; bus.exm_result = 0;
      bus.mwb_rd = 0; bus.mwb_reg_write = 0; bus.mwb_result = 0;
   endtask

   task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [1:0] op,
                         input logic rw, input logic mr);
      bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
      bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = 32'h0;
      bus.id_use_imm = 0; bus.id_alu_op = alu_op_e'(op);
      bus.id_reg_write = rw; bus.id_mem_read = mr;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Forwarding rule: EX/MEM, then MEM/WB, then the captured value; x0 never.
   function automatic logic [31:0] fwd_ref(input logic [4:0] rs, input logic [31:0] cap);
      if (rs != 0 && bus.exm_reg_write && bus.exm_rd == rs) return bus.exm_result;
      if (rs != 0 && bus.mwb_reg_write && bus.mwb_rd == rs) return bus.mwb_result;
      return cap;
   endfunction

   function automatic logic lu_ref();
      return m.valid && m.mr && m.rd != 0 && bus.id_valid &&
             (m.rd == bus.id_rs1 || m.rd == bus.id_rs2);
   endfunction

   initial begin
      idle();
      m = '{default: '0};

      // ---- reset ----
      #3;
      check("rst_ex_valid", bus.ex_valid, 0);
      check("rst_aluop", bus.ALUOp, 0);
      @(negedge clk);
      rst_n = 1;
      set_id(5'd1, 5'd2, 5'd9, 32'h1, 32'h2, 2'b11, 1, 0);
      step();
      check("pre_rst_valid", bus.ex_valid, 1);
      check("pre_rst_aluop", bus.ALUOp, 3);
      check("pre_rst_rd", bus.ex_rd, 9);
      #2 rst_n = 0;
      #1;
      check("mid_rst_valid", bus.ex_valid, 0);
      check("mid_rst_aluop", bus.ALUOp, 0);
      check("mid_rst_rd", bus.ex_rd, 0);
      check("mid_rst_rw", bus.ex_reg_write, 0);
      @(negedge clk);
      rst_n = 1;

      // ---- ADD x3,x1,x2 with x1=5, x2=7 ----
      idle();
      set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 2'b00, 1, 0);
      step();
      check("add_valid", bus.ex_valid, 1);
      check("add_A", bus.A, 5);
      check("add_B", bus.B, 7);
      check("add_aluop", bus.ALUOp, 0);
      check("add_rd", bus.ex_rd, 3);
      check("add_rw", bus.ex_reg_write, 1);

      // ---- forwarding priority and x0 ----
      bus.id_valid = 0;
      bus.exm_rd = 1; bus.exm_reg_write = 1; bus.exm_result = 32'h10;
      bus.mwb_rd = 1; bus.mwb_reg_write = 1; bus.mwb_result = 32'h20;
      #1 check("fwd_exm_A", bus.A, 32'h10);
      bus.exm_rd = 0; bus.exm_result = 32'h30;
      #1 check("fwd_mwb_A", bus.A, 32'h20);
      bus.exm_rd = 2; bus.exm_result = 32'h44;
      #1 check("fwd_exm_B", bus.B, 32'h44);
      check("fwd_exm_store", bus.ex_store_data, 32'h44);

      // ---- load-use: LW x4 then ADD x5,x4,x1 ----
      step();
      idle();
      set_id(5'd2, 5'd0, 5'd4, 32'h100, 32'h0, 2'b00, 1, 1);
      step();
      check("lw_mem_read", bus.ex_mem_read, 1);
      set_id(5'd4, 5'd1, 5'd5, 32'h0, 32'h11, 2'b00, 1, 0);
      #1 check("lu_stall", bus.id_stall, 1);
      step();
      check("lu_bubble", bus.ex_valid, 0);
      check("lu_stall_clear", bus.id_stall, 0);
      bus.exm_rd = 4; bus.exm_reg_write = 1; bus.exm_result = 32'h400;
      step();
      bus.exm_rd = 0; bus.exm_reg_write = 0; bus.exm_result = 0;
      bus.mwb_rd = 4; bus.mwb_reg_write = 1; bus.mwb_result = 32'hDEAD;
      #1;
      check("lu_add_valid", bus.ex_valid, 1);
      check("lu_add_A", bus.A, 32'hDEAD);
      check("lu_add_B", bus.B, 32'h11);
      check("lu_add_rd", bus.ex_rd, 5);

      // ---- flush together with load-use ----
      idle();
      set_id(5'd2, 5'd0, 5'd4, 32'h100, 32'h0, 2'b00, 1, 1);
      step();
      set_id(5'd1, 5'd4, 5'd6, 32'h1, 32'h2, 2'b00, 1, 0);
      bus.flush = 1;
      #1 check("flush_lu_stall", bus.id_stall, 0);
      step();
      check("flush_valid", bus.ex_valid, 0);
      check("flush_rw", bus.ex_reg_write, 0);

      // ---- hold for 3 cycles ----
      idle();
      set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 2'b00, 1, 0);
      step();
      bus.hold = 1;
      set_id(5'd6, 5'd7, 5'd8, 32'd9, 32'd9, 2'b01, 1, 0);
      for (int i = 0; i < 3; i++) begin
         #1 check("hold_stall", bus.id_stall, 1);
         step();
         check("hold_A", bus.A, 5);
         check("hold_B", bus.B, 7);
         check("hold_aluop", bus.ALUOp, 0);
         check("hold_rd", bus.ex_rd, 3);
      end

      // ---- randomized traffic against the model ----
      idle();
      @(negedge clk);
      rst_n = 0;
      #1 rst_n = 1;
      m = '{default: '0};
      for (int cyc = 0; cyc < 500; cyc++) begin
         logic [31:0] exp_b;
         @(negedge clk);
         bus.id_valid     = $urandom_range(0, 3) != 0;
         bus.id_rs1       = 5'($urandom_range(0, 3));
         bus.id_rs2       = 5'($urandom_range(0, 3));
         bus.id_rd        = 5'($urandom_range(0, 3));
         bus.id_rs1_data  = $urandom();
         bus.id_rs2_data  = $urandom();
         bus.id_imm       = $urandom();
         bus.id_use_imm   = 1'($urandom_range(0, 1));
         bus.id_alu_op    = alu_op_e'($urandom_range(0, 3));
         bus.id_reg_write = 1'($urandom_range(0, 1));
         bus.id_mem_read  = $urandom_range(0, 2) == 0;
         bus.flush        = $urandom_range(0, 9) == 0;
         bus.hold         = $urandom_range(0, 6) == 0;
         bus.exm_rd       = 5'($urandom_range(0, 3));
         bus.exm_reg_write = 1'($urandom_range(0, 1));
         bus.exm_result   = $urandom();
         bus.mwb_rd       = 5'($urandom_range(0, 3));
         bus.mwb_reg_write = 1'($urandom_range(0, 1));
         bus.mwb_result   = $urandom();
         #1;
         check("r_valid", bus.ex_valid, m.valid);
         check("r_stall", bus.id_stall, (lu_ref() || bus.hold) && !bus.flush);
         check("r_rw", bus.ex_reg_write, m.valid && m.rw);
         check("r_mr", bus.ex_mem_read, m.valid && m.mr);
         if (m.valid) begin
            exp_b = m.use_imm ? m.imm : fwd_ref(m.rs2, m.v2);
            check("r_A", bus.A, fwd_ref(m.rs1, m.v1));
            check("r_B", bus.B, exp_b);
            check("r_store", bus.ex_store_data, fwd_ref(m.rs2, m.v2));
            check("r_aluop", bus.ALUOp, m.op);
            check("r_rd", bus.ex_rd, m.rd);
         end
         @(posedge clk);
         if (bus.flush) m.valid = 0;
         else if (bus.hold) ;
         else if (lu_ref()) m.valid = 0;
         else begin
            m.valid   = bus.id_valid;
            m.rs1     = bus.id_rs1;
            m.rs2     = bus.id_rs2;
            m.rd      = bus.id_rd;
            m.v1      = (bus.mwb_reg_write && bus.mwb_rd != 0 && bus.mwb_rd == bus.id_rs1)
                        ? bus.mwb_result : bus.id_rs1_data;
            m.v2      = (bus.mwb_reg_write && bus.mwb_rd != 0 && bus.mwb_rd == bus.id_rs2)
                        ? bus.mwb_result : bus.id_rs2_data;
            m.imm     = bus.id_imm;
            m.use_imm = bus.id_use_imm;
            m.op      = bus.id_alu_op;
            m.rw      = bus.id_reg_write;
            m.mr      = bus.id_mem_read;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
